// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one 4-bit magnitude comparator among NREQ requesters.
// A winner is granted, its operands are latched and compared, and the result returns with a done pulse.

module mag_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       agtb,
  output logic       altb,
  output logic       aeqb
);
  assign agtb = (a > b);
  assign altb = (a < b);
  assign aeqb = (a == b);
endmodule

module cmp_rr_sched #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    a_in,
  input  logic [4*NREQ-1:0]    b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 agtb,
  output logic                 altb,
  output logic                 aeqb,
  output logic                 busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] CMP   = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] win_next;
  logic [IW-1:0] pick;
  logic          found;
  int            cand;
  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic          c_gt;
  logic          c_lt;
  logic          c_eq;
  logic [3:0]    a_arr [NREQ];
  logic [3:0]    b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_arr[g] = a_in[4*g +: 4];
    assign b_arr[g] = b_in[4*g +: 4];
  end

  // First requester at or above the pointer, wrapping past NREQ-1 back to 0.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  assign win_next = (win == IW'(NREQ-1)) ? '0 : win + IW'(1);

  mag_cmp4 u_cmp (
    .a    (a_q),
    .b    (b_q),
    .agtb (c_gt),
    .altb (c_lt),
    .aeqb (c_eq)
  );

  // An abort (winner drops req in GRANT/CMP) still moves the pointer past the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      agtb  <= 1'b0;
      altb  <= 1'b0;
      aeqb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            win   <= pick;
            a_q   <= a_arr[pick];
            b_q   <= b_arr[pick];
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[win]) begin
            ptr   <= win_next;
            state <= IDLE;
          end else begin
            state <= CMP;
          end
        end
        CMP: begin
          if (!req[win]) begin
            ptr   <= win_next;
            state <= IDLE;
          end else begin
            agtb  <= c_gt;
            altb  <= c_lt;
            aeqb  <= c_eq;
            state <= RESP;
          end
        end
        RESP: begin
          ptr   <= win_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    if (state != IDLE) gnt[win] = 1'b1;
    if (state == RESP) done[win] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule
